// File: rtl/if_fetch_stage_if.sv
// rtl/if_fetch_stage_if.sv - instruction-memory request/ready bus between fetch stage and imem
interface if_fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - instruction fetch stage with stall/redirect handling (optional perf counters: IF_FETCH_PERF_EN)
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h00000000,
    parameter logic [31:0] PC_INC   = 32'd4
) (
    input  logic                   Clk,
    input  logic                   Rst_n,
    input  logic                   stall,
    input  logic                   redirect,
    input  logic [31:0]            redirect_target,
    if_fetch_stage_if.master       imem,
    output logic [31:0]            PC_out,
    output logic [31:0]            IR_out,
    output logic                   IF_valid,
    output logic                   fetch_wait,
    output logic [31:0]            perf_fetch_cnt,
    output logic [31:0]            perf_wait_cnt
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_KILL  = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] ir_hold;
    logic [31:0] pend_target;
    logic [31:0] target;

    assign target = redirect_target & ~32'h3;
    assign PC_out = pc + PC_INC;

    // Reset gates the request combinationally so an in-flight fetch dies at once.
    always_comb begin
        imem.imem_req  = 1'b0;
        imem.imem_addr = pc;
        IF_valid       = 1'b0;
        IR_out         = 32'h0;
        fetch_wait     = 1'b0;
        if (Rst_n) begin
            case (state)
                S_FETCH: begin
                    imem.imem_req = 1'b1;
                    if (!imem.imem_ready) begin
                        fetch_wait = 1'b1;
                    end else if (!redirect) begin
                        IF_valid = 1'b1;
                        IR_out   = imem.imem_rdata;
                    end
                end
                S_HOLD: begin
                    IF_valid = 1'b1;
                    IR_out   = ir_hold;
                end
                S_KILL: begin
                    imem.imem_req = 1'b1;
                    fetch_wait    = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state       <= S_FETCH;
            pc          <= RESET_PC;
            ir_hold     <= 32'h0;
            pend_target <= 32'h0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (imem.imem_ready) begin
                        if (redirect) begin
                            pc <= target;
                        end else if (stall) begin
                            ir_hold <= imem.imem_rdata;
                            state   <= S_HOLD;
                        end else begin
                            pc <= pc + PC_INC;
                        end
                    end else if (redirect) begin
                        // Address must stay stable, so wait out the request before redirecting.
                        pend_target <= target;
                        state       <= S_KILL;
                    end
                end
                S_HOLD: begin
                    if (redirect) begin
                        pc    <= target;
                        state <= S_FETCH;
                    end else if (!stall) begin
                        pc    <= pc + PC_INC;
                        state <= S_FETCH;
                    end
                end
                S_KILL: begin
                    if (imem.imem_ready) begin
                        pc    <= redirect ? target : pend_target;
                        state <= S_FETCH;
                    end else if (redirect) begin
                        pend_target <= target;
                    end
                end
                default: state <= S_FETCH;
            endcase
        end
    end

`ifdef IF_FETCH_PERF_EN
    logic [31:0] fetch_cnt;
    logic [31:0] wait_cnt;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            fetch_cnt <= 32'h0;
            wait_cnt  <= 32'h0;
        end else begin
            if (IF_valid && !stall) fetch_cnt <= fetch_cnt + 32'd1;
            if (fetch_wait)         wait_cnt  <= wait_cnt + 32'd1;
        end
    end

    assign perf_fetch_cnt = fetch_cnt;
    assign perf_wait_cnt  = wait_cnt;
`else
    assign perf_fetch_cnt = 32'h0;
    assign perf_wait_cnt  = 32'h0;
`endif

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage sitting directly upstream of the IF/ID pipeline register.
- Owns the PC, runs the request/ready handshake to instruction memory, and handles hazard stalls and branch/jump redirects.
- Presents PC+4 and the fetched instruction to IF/ID each cycle; presents NOP (32'h00000000) when no valid instruction is available.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- PC_INC, 32'd4, sequential PC increment.

Ports:
- Clk  in  1  system clock, rising edge.
- Rst_n  in  1  asynchronous, active-low reset.
- stall  in  1  hazard stall; the same signal drives the IF/ID stall input.
- redirect  in  1  taken branch/jump; one-cycle pulse from a later stage.
- redirect_target  in  32  new PC; bits [1:0] are ignored and forced to 0.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  fetch address; held stable while imem_req=1 and imem_ready=0.
- imem_ready  in  1  imem_rdata is valid for imem_addr this cycle.
- imem_rdata  in  32  instruction word.
- PC_out  out  32  fetched PC + PC_INC, feeds IF/ID PC_in.
- IR_out  out  32  instruction, feeds IF/ID IR_in; 0 when IF_valid=0.
- IF_valid  out  1  IR_out holds a valid, correct-path instruction.
- fetch_wait  out  1  high while waiting on memory; used by the hazard unit to bubble IF/ID.
- perf_fetch_cnt  out  32  see Optional Feature.
- perf_wait_cnt  out  32  see Optional Feature.

Behaviour:
- Reset (async, Rst_n=0):
  - PC=RESET_PC, state=S_FETCH, hold/pending registers=0, imem_req=0.
  - IF_valid=0, IR_out=0, PC_out=RESET_PC+PC_INC, fetch_wait=0.
  - After release, the first request is issued in the first cycle.
- Registers: PC, state, IR_hold, pend_target.
- S_FETCH:
  - imem_req=1, imem_addr=PC. If imem_ready=0: fetch_wait=1, IF_valid=0, stay.
  - imem_ready=1 and redirect=1: discard rdata, IF_valid=0, PC<=target, stay S_FETCH. Redirect has priority over stall.
  - imem_ready=1, stall=1: IF_valid=1, IR_out=imem_rdata, IR_hold<=imem_rdata, go S_HOLD; PC unchanged.
  - imem_ready=1, stall=0: IF_valid=1, IR_out=imem_rdata, PC<=PC+PC_INC, stay S_FETCH. Zero-bubble back-to-back fetch when memory is single-cycle.
  - imem_ready=0 and redirect=1: pend_target<=target, go S_KILL. The address must stay stable, so the in-flight request is not abandoned.
- S_HOLD:
  - imem_req=0, IF_valid=1, IR_out=IR_hold, PC_out=PC+PC_INC.
  - redirect=1: PC<=target, go S_FETCH.
  - else stall=0: PC<=PC+PC_INC, go S_FETCH.
  - else stay.
- S_KILL:
  - imem_req=1, imem_addr=old PC, IF_valid=0, fetch_wait=1.
  - A redirect here overwrites pend_target; the latest redirect wins.
  - On imem_ready: discard rdata, PC<=pend_target, go S_FETCH.
- Output rules:
  - PC_out = PC + PC_INC in all states, 32-bit wrap-around (32'hFFFFFFFC + 4 = 0).
  - IR_out is forced to 0 whenever IF_valid=0.
- Outputs are combinational from state, PC, IR_hold and memory inputs; the IF/ID register supplies the pipeline flop.
- A reset asserted mid-request kills the request immediately (imem_req=0). The memory model must drop it as well.
- Misaligned redirect: a target of 32'h00000013 loads PC=32'h00000010.

Optional Feature:
- Macro IF_FETCH_PERF_EN.
- Defined:
  - perf_fetch_cnt increments each cycle IF_valid=1 and stall=0 (instruction accepted).
  - perf_wait_cnt increments each cycle fetch_wait=1.
  - Both are 32-bit, wrap at 2^32, and clear on reset.
- Undefined: both outputs tied to 32'h0; no counter flops are synthesized.

Test Plan:
- Single-cycle memory (imem_ready=1 always), no stall, reset release → imem_addr 0,4,8,12 on consecutive cycles; PC_out 4,8,12,16; IF_valid=1 every cycle.
- Memory with 2 wait cycles at addr 0 → fetch_wait=1 and IR_out=0 for 2 cycles, then IF_valid=1 with rdata; next request addr=4.
- stall=1 for 3 cycles while rdata=32'h8C220004 → S_HOLD, imem_req=0, IR_out stays 32'h8C220004; after stall drops next addr=PC+4.
- redirect to 32'h00000040 while request at 32'h8 is waiting → imem_addr stays 32'h8 until ready, that response is discarded (IF_valid=0), next request is 32'h40.
- Second redirect to 32'h80 during S_KILL, plus a redirect simultaneous with imem_ready → next fetch 32'h80; simultaneous case drops rdata and fetches the target next cycle.
- Rst_n pulsed low mid-wait → imem_req=0 immediately, PC=RESET_PC. With IF_FETCH_PERF_EN, counters read 0 after reset and match accepted/wait cycle counts over a 20-cycle run.
